// File: rtl/gpc_imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package gpc_imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/gpc_imem_array.sv
// DEPTH x INST_MAX instruction storage: synchronous write, asynchronous read.
// Contents are never reset so a preload survives core resets.
module gpc_imem_array
    import gpc_imem_pkg::*;
#(
    parameter int INST_MAX = 32,
    parameter int DEPTH    = 1024,
    parameter int IW       = clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_idx,
    input  logic [INST_MAX-1:0] wr_data,
    input  logic [IW-1:0]       rd_idx,
    output logic [INST_MAX-1:0] rd_data
);

    logic [INST_MAX-1:0] mem [DEPTH];

    // Preload write port; reads see the pre-edge contents (read-before-write).
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/gpc_imem_responder.sv
// Memory end of the fetch interface: one request in flight, response after
// LATENCY cycles. Define IMEM_ERR_EN to flag misaligned / out-of-range fetches
// with resp_err; otherwise low address bits are ignored and addresses wrap.
module gpc_imem_responder
    import gpc_imem_pkg::*;
#(
    parameter int                INST_MAX = 32,
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  PC_START = 32'h8000_0000,
    parameter int                DEPTH    = 1024,
    parameter int                LATENCY  = 1,
    localparam int               IW       = clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [WIDTH-1:0]    req_addr,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [INST_MAX-1:0] resp_inst,
    output logic                resp_err,
    input  logic                ld_en,
    input  logic [IW-1:0]       ld_idx,
    input  logic [INST_MAX-1:0] ld_data
);

    localparam int CW = clog2(LATENCY + 1);

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [WIDTH-1:0]    addr_q, addr_n;
    logic [INST_MAX-1:0] inst_n;
    logic                err_n;

    logic [WIDTH-1:0]    rd_addr;
    logic [WIDTH-1:0]    off;
    logic [IW-1:0]       rd_idx;
    logic [INST_MAX-1:0] rd_data;
    logic                bad;

    // In IDLE a zero-wait accept reads straight from the request bus;
    // otherwise the latched address drives the read.
    assign rd_addr = (state == ST_IDLE) ? req_addr : addr_q;
    assign off     = rd_addr - PC_START;
    assign rd_idx  = off[IW+1:2];

`ifdef IMEM_ERR_EN
    localparam logic [WIDTH:0] OOR_LIM = (WIDTH + 1)'(DEPTH) << 2;
    assign bad = (rd_addr[1:0] != 2'b00) || (rd_addr < PC_START) ||
                 ({1'b0, off} >= OOR_LIM);
`else
    assign bad = 1'b0;
`endif

    // Only the word-index bits of the offset matter when faults are off.
    logic unused_off;
    assign unused_off = ^off;

    gpc_imem_array #(.INST_MAX(INST_MAX), .DEPTH(DEPTH), .IW(IW)) u_array (
        .clk     (clk),
        .wr_en   (ld_en),
        .wr_idx  (ld_idx),
        .wr_data (ld_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);

    // State, wait counter, latched address and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            resp_inst <= '0;
            resp_err  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            addr_q    <= addr_n;
            resp_inst <= inst_n;
            resp_err  <= err_n;
        end
    end

    // Next-state logic; a capture loads the response registers from the array.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = addr_q;
        inst_n  = resp_inst;
        err_n   = resp_err;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_n = req_addr;
                    cnt_n  = CW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        inst_n  = bad ? '0 : rd_data;
                        err_n   = bad;
                        state_n = ST_RESP;
                    end else begin
                        state_n = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    inst_n  = bad ? '0 : rd_data;
                    err_n   = bad;
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gpc_imem_responder.sv
// Directed bench: three responders (LATENCY 1, 3, 4) share clock, reset,
// preload port, address and resp_ready; each has its own req_valid.
// Observed vector per instance = {req_ready, resp_valid, resp_err, resp_inst}.
module tb_gpc_imem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_en = 1'b0;
    logic [9:0]  ld_idx = '0;
    logic [31:0] ld_data = '0;
    logic        resp_ready = 1'b0;
    logic [31:0] req_addr = '0;
    logic [2:0]  req_valid = '0;

    logic [2:0]  req_ready, resp_valid, resp_err;
    logic [31:0] inst1, inst3, inst4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gpc_imem_responder #(.LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr), .resp_valid(resp_valid[0]), .resp_ready(resp_ready),
        .resp_inst(inst1), .resp_err(resp_err[0]),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data));

    gpc_imem_responder #(.LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr), .resp_valid(resp_valid[1]), .resp_ready(resp_ready),
        .resp_inst(inst3), .resp_err(resp_err[1]),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data));

    gpc_imem_responder #(.LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr), .resp_valid(resp_valid[2]), .resp_ready(resp_ready),
        .resp_inst(inst4), .resp_err(resp_err[2]),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data));

    logic [34:0] s1, s3, s4;
    assign s1 = {req_ready[0], resp_valid[0], resp_err[0], inst1};
    assign s3 = {req_ready[1], resp_valid[1], resp_err[1], inst3};
    assign s4 = {req_ready[2], resp_valid[2], resp_err[2], inst4};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        ld_en = 1'b1; ld_idx = idx; ld_data = data;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        // Preload while reset is held: writes must still land.
        preload(10'd0, 32'h0010_0093);
        preload(10'd1, 32'h1111_1111);
        preload(10'd2, 32'hDEAD_BEEF);
        preload(10'd1023, 32'hCAFE_F00D);
        checks++; if (s1 !== {3'b100, 32'h0}) begin errors++; $display("FAIL reset_l1 got %h exp %h", s1, {3'b100, 32'h0}); end
        checks++; if (s3 !== {3'b100, 32'h0}) begin errors++; $display("FAIL reset_l3 got %h exp %h", s3, {3'b100, 32'h0}); end
        checks++; if (s4 !== {3'b100, 32'h0}) begin errors++; $display("FAIL reset_l4 got %h exp %h", s4, {3'b100, 32'h0}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_fetch();
        resp_ready = 1'b1;
        req_addr = 32'h8000_0000; req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        checks++; if (s1 !== {3'b010, 32'h0010_0093}) begin errors++; $display("FAIL basic_resp got %h exp %h", s1, {3'b010, 32'h0010_0093}); end
        tick();
        checks++; if (s1 !== {3'b100, 32'h0010_0093}) begin errors++; $display("FAIL basic_idle got %h exp %h", s1, {3'b100, 32'h0010_0093}); end
    endtask

    task automatic test_latency3();
        resp_ready = 1'b1;
        req_addr = 32'h8000_0008; req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        checks++; if (s3 !== {3'b000, 32'h0}) begin errors++; $display("FAIL lat3_e0 got %h exp %h", s3, {3'b000, 32'h0}); end
        tick();
        checks++; if (s3 !== {3'b000, 32'h0}) begin errors++; $display("FAIL lat3_e1 got %h exp %h", s3, {3'b000, 32'h0}); end
        tick();
        checks++; if (s3 !== {3'b010, 32'hDEAD_BEEF}) begin errors++; $display("FAIL lat3_e2 got %h exp %h", s3, {3'b010, 32'hDEAD_BEEF}); end
        tick();
        checks++; if (s3 !== {3'b100, 32'hDEAD_BEEF}) begin errors++; $display("FAIL lat3_idle got %h exp %h", s3, {3'b100, 32'hDEAD_BEEF}); end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        req_addr = 32'h8000_0004; req_valid[0] = 1'b1;
        tick();
        // Keep requesting a different word; it must be ignored.
        req_addr = 32'h8000_0008;
        for (int i = 0; i < 5; i++) begin
            checks++; if (s1 !== {3'b010, 32'h1111_1111}) begin errors++; $display("FAIL bp_hold%0d got %h exp %h", i, s1, {3'b010, 32'h1111_1111}); end
            tick();
        end
        resp_ready = 1'b1;
        checks++; if (s1 !== {3'b010, 32'h1111_1111}) begin errors++; $display("FAIL bp_pre_hs got %h exp %h", s1, {3'b010, 32'h1111_1111}); end
        tick();
        // Handshake edge must not also accept the pending request.
        checks++; if (s1 !== {3'b100, 32'h1111_1111}) begin errors++; $display("FAIL bp_after_hs got %h exp %h", s1, {3'b100, 32'h1111_1111}); end
        resp_ready = 1'b0;
        tick();
        req_valid[0] = 1'b0;
        checks++; if (s1 !== {3'b010, 32'hDEAD_BEEF}) begin errors++; $display("FAIL bp_second got %h exp %h", s1, {3'b010, 32'hDEAD_BEEF}); end
        resp_ready = 1'b1;
        tick();
    endtask

    task automatic test_rbw();
        resp_ready = 1'b0;
        req_addr = 32'h8000_0004; req_valid[0] = 1'b1;
        ld_en = 1'b1; ld_idx = 10'd1; ld_data = 32'h2222_2222;
        tick();
        req_valid[0] = 1'b0; ld_en = 1'b0;
        checks++; if (s1 !== {3'b010, 32'h1111_1111}) begin errors++; $display("FAIL rbw_old got %h exp %h", s1, {3'b010, 32'h1111_1111}); end
        resp_ready = 1'b1;
        tick();
        req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        checks++; if (s1 !== {3'b010, 32'h2222_2222}) begin errors++; $display("FAIL rbw_new got %h exp %h", s1, {3'b010, 32'h2222_2222}); end
        tick();
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b1;
        req_addr = 32'h8000_0008; req_valid[2] = 1'b1;
        tick();
        req_valid[2] = 1'b0;
        tick();
        checks++; if (s4 !== {3'b000, 32'h0}) begin errors++; $display("FAIL rstmid_wait got %h exp %h", s4, {3'b000, 32'h0}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (s4 !== {3'b100, 32'h0}) begin errors++; $display("FAIL rstmid_drop%0d got %h exp %h", i, s4, {3'b100, 32'h0}); end
            tick();
        end
        req_addr = 32'h8000_0008; req_valid[2] = 1'b1;
        tick();
        req_valid[2] = 1'b0;
        tick(); tick();
        checks++; if (s4 !== {3'b000, 32'h0}) begin errors++; $display("FAIL rstmid_lat got %h exp %h", s4, {3'b000, 32'h0}); end
        tick();
        checks++; if (s4 !== {3'b010, 32'hDEAD_BEEF}) begin errors++; $display("FAIL rstmid_mem got %h exp %h", s4, {3'b010, 32'hDEAD_BEEF}); end
        tick();
    endtask

    task automatic test_addr();
        logic [31:0] addrs [4];
        logic [34:0] exp  [4];
        addrs[0] = 32'h8000_0002;
        addrs[1] = 32'h8000_1000;
        addrs[2] = 32'h7FFF_FFFC;
        addrs[3] = 32'h8000_0FFC;
`ifdef IMEM_ERR_EN
        exp[0] = {3'b011, 32'h0};
        exp[1] = {3'b011, 32'h0};
        exp[2] = {3'b011, 32'h0};
`else
        exp[0] = {3'b010, 32'h0010_0093};
        exp[1] = {3'b010, 32'h0010_0093};
        exp[2] = {3'b010, 32'hCAFE_F00D};
`endif
        exp[3] = {3'b010, 32'hCAFE_F00D};
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = addrs[i]; req_valid[0] = 1'b1;
            tick();
            req_valid[0] = 1'b0;
            checks++; if (s1 !== exp[i]) begin errors++; $display("FAIL addr_%h got %h exp %h", addrs[i], s1, exp[i]); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_latency3();
        test_backpressure();
        test_rbw();
        test_reset_mid();
        test_addr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
